// File: rtl/register_file.sv
// Two-read, one-write register file. Register 0 is hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read1_addr,
  input  logic [ADDR_WIDTH-1:0] read2_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  // Entry 0 has no storage; the array starts at 1.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd1_c;
  logic [DATA_WIDTH-1:0] rd2_c;

  // Next-state: only the addressed entry takes data_in; address 0 matches nothing.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (write_addr == ADDR_WIDTH'(i)) begin
        regs_d[i] = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Stored-value read muxes; address 0 falls through to zero.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (read1_addr == ADDR_WIDTH'(i)) begin
        rd1_c = regs_q[i];
      end
      if (read2_addr == ADDR_WIDTH'(i)) begin
        rd2_c = regs_q[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_valid_c;
  logic byp1_c;
  logic byp2_c;

  assign wr_valid_c = (write_addr != '0);
  assign byp1_c     = wr_valid_c && (read1_addr == write_addr);
  assign byp2_c     = wr_valid_c && (read2_addr == write_addr);

  // Reset dominates forwarding so outputs stay zero while rst is low.
  always_comb begin
    data_out1 = '0;
    data_out2 = '0;
    if (rst) begin
      data_out1 = byp1_c ? data_in : rd1_c;
      data_out2 = byp2_c ? data_in : rd2_c;
    end
  end
`else
  always_comb begin
    data_out1 = '0;
    data_out2 = '0;
    if (rst) begin
      data_out1 = rd1_c;
      data_out2 = rd2_c;
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file; expectations are hand-computed constants.
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] read1_addr;
  logic [AW-1:0] read2_addr;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out1;
  logic [DW-1:0] data_out2;

  int n_vec;
  int n_bad;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .read1_addr (read1_addr),
    .read2_addr (read2_addr),
    .write_addr (write_addr),
    .data_in    (data_in),
    .data_out1  (data_out1),
    .data_out2  (data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    write_addr = a;
    data_in    = d;
    @(posedge clk);
    #1;
    write_addr = '0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    read1_addr = a1;
    read2_addr = a2;
    #1;
    check({tag, "_p1"}, data_out1, e1);
    check({tag, "_p2"}, data_out2, e2);
  endtask

  initial begin
    logic [DW-1:0] v;
    n_vec      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    read1_addr = '0;
    read2_addr = '0;
    write_addr = '0;
    data_in    = '0;

    // Reset state: everything reads zero.
    #2;
    read_chk("rst_a0", 5'd0, 5'd31, 32'h0, 32'h0);
    read_chk("rst_a5", 5'd5, 5'd17, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fill 1..31 with addr*01010101 and read everything back.
    for (int a = 1; a < 32; a++) begin
      v = DW'(a) * 32'h01010101;
      write_reg(AW'(a), v);
    end
    for (int a = 0; a < 32; a++) begin
      v = DW'(a) * 32'h01010101;
      read_chk($sformatf("fill%0d", a), AW'(a), AW'(31 - a), v, DW'(31 - a) * 32'h01010101);
    end

    // Write to address 0 is discarded.
    write_reg(5'd0, 32'hFFFFFFFF);
    read_chk("wr0", 5'd0, 5'd1, 32'h0, 32'h01010101);

    // Distinct and equal addresses; neighbours untouched.
    write_reg(5'd3, 32'hDEADBEEF);
    write_reg(5'd31, 32'h00000001);
    read_chk("rs_rt", 5'd3, 5'd31, 32'hDEADBEEF, 32'h00000001);
    read_chk("same", 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF);
    read_chk("nbr", 5'd4, 5'd30, 32'h04040404, 32'h1E1E1E1E);

    // Same-cycle write/read of reg7.
    write_reg(5'd7, 32'hA);
    @(negedge clk);
    write_addr = 5'd7;
    data_in    = 32'hB;
`ifdef REGFILE_BYPASS_EN
    read_chk("byp_pre", 5'd7, 5'd0, 32'hB, 32'h0);
`else
    read_chk("byp_pre", 5'd7, 5'd0, 32'hA, 32'h0);
`endif
    @(posedge clk);
    #1;
    write_addr = '0;
    read_chk("byp_post", 5'd7, 5'd7, 32'hB, 32'hB);

    // Address 0 is never forwarded.
    @(negedge clk);
    write_addr = 5'd0;
    data_in    = 32'h77777777;
    read_chk("byp_a0", 5'd0, 5'd0, 32'h0, 32'h0);

    // Asynchronous reset mid-cycle clears without a clock edge.
    write_reg(5'd5, 32'h12345678);
    read_chk("r5_set", 5'd5, 5'd5, 32'h12345678, 32'h12345678);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst", data_out1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    read_chk("r5_after", 5'd5, 5'd3, 32'h0, 32'h0);

    // Reset coincident with a write to reg9; outputs forced zero meanwhile.
    write_reg(5'd1, 32'h11);
    @(negedge clk);
    write_addr = 5'd9;
    data_in    = 32'h55;
    rst        = 1'b0;
    read_chk("rst_wr_out", 5'd9, 5'd1, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    write_addr = '0;
    @(negedge clk);
    rst = 1'b1;
    read_chk("rst_wr_r9", 5'd9, 5'd1, 32'h0, 32'h0);

    // First write after release lands on the first rising edge.
    write_reg(5'd12, 32'hCAFEF00D);
    read_chk("first_wr", 5'd12, 5'd9, 32'hCAFEF00D, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
